// File: rtl/gate_unit_pipe_if.sv
// gate_unit_pipe_if
//   Bundles the operand/result handshake of gate_unit_pipe.
//   master : bench or stimulus driver (drives operands, observes results)
//   slave  : gate_unit_pipe (consumes operands, drives results)
//   Signals:
//     in_valid, op[2:0], p/q[WIDTH-1:0], acc_clr      -> toward the pipe
//     out_valid, result[2*WIDTH-1:0], red_and, red_or,
//     red_xor, zero, op_count[7:0]                     <- from the pipe
interface gate_unit_pipe_if #(
    parameter int WIDTH = 5
);
    logic                 in_valid;
    logic [2:0]           op;
    logic [WIDTH-1:0]     p;
    logic [WIDTH-1:0]     q;
    logic                 acc_clr;
    logic                 out_valid;
    logic [2*WIDTH-1:0]   result;
    logic                 red_and;
    logic                 red_or;
    logic                 red_xor;
    logic                 zero;
    logic [7:0]           op_count;

    modport master (
        output in_valid, op, p, q, acc_clr,
        input  out_valid, result, red_and, red_or, red_xor, zero, op_count
    );

    modport slave (
        input  in_valid, op, p, q, acc_clr,
        output out_valid, result, red_and, red_or, red_xor, zero, op_count
    );
endinterface

// File: rtl/gate_unit_pipe.sv
// gate_unit_pipe
//   Two-stage pipelined gate/arithmetic unit. Stage 1 registers the
//   operands; stage 2 computes one of eight operations and registers the
//   zero-extended result plus reduction flags. An internal accumulator
//   supports multiply-accumulate, and op_count tallies accepted operations.
//   Ports:
//     clk  - rising-edge clock
//     rst  - asynchronous active-high reset
//     bus  - gate_unit_pipe_if.slave (operands in, result/flags out)
module gate_unit_pipe #(
    parameter int WIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    gate_unit_pipe_if.slave   bus
);

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_ADD  = 3'd5,
        OP_MUL  = 3'd6,
        OP_ACC  = 3'd7
    } op_e;

    localparam int RW = 2 * WIDTH;

    // Stage 1 registers: capture only, no computation.
    logic             s1_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_p;
    logic [WIDTH-1:0] s1_q;

    logic [RW-1:0]    acc;

    // Stage 2 combinational results.
    logic [RW-1:0]    p_ext;
    logic [RW-1:0]    q_ext;
    logic [RW-1:0]    prod;
    logic [WIDTH:0]   sum;
    logic [RW-1:0]    acc_base;
    logic [RW-1:0]    acc_next;
    logic [RW-1:0]    nxt_result;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        p_ext      = {{WIDTH{1'b0}}, s1_p};
        q_ext      = {{WIDTH{1'b0}}, s1_q};
        prod       = p_ext * q_ext;
        sum        = {1'b0, s1_p} + {1'b0, s1_q};
        // The clear is sampled alongside the ACC sitting in stage 2, so a
        // coincident clear restarts the sum from this product alone.
        acc_base   = bus.acc_clr ? '0 : acc;
        acc_next   = acc_base + prod;
        nxt_result = '0;
        unique case (s1_op)
            OP_AND:  nxt_result = {{WIDTH{1'b0}}, s1_p & s1_q};
            OP_OR:   nxt_result = {{WIDTH{1'b0}}, s1_p | s1_q};
            OP_XOR:  nxt_result = {{WIDTH{1'b0}}, s1_p ^ s1_q};
            OP_NAND: nxt_result = {{WIDTH{1'b0}}, ~(s1_p & s1_q)};
            OP_NOR:  nxt_result = {{WIDTH{1'b0}}, ~(s1_p | s1_q)};
            OP_ADD:  nxt_result = {{(WIDTH-1){1'b0}}, sum};
            OP_MUL:  nxt_result = prod;
            OP_ACC:  nxt_result = acc_next;
            default: nxt_result = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and the two stages stay in lockstep.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            s1_op         <= OP_AND;
            s1_p          <= '0;
            s1_q          <= '0;
            acc           <= '0;
            bus.out_valid <= 1'b0;
            bus.result    <= '0;
            bus.red_and   <= 1'b0;
            bus.red_or    <= 1'b0;
            bus.red_xor   <= 1'b0;
            bus.zero      <= 1'b0;
            bus.op_count  <= 8'd0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_op    <= op_e'(bus.op);
            s1_p     <= bus.p;
            s1_q     <= bus.q;

            if (bus.in_valid) begin
                bus.op_count <= bus.op_count + 8'd1;
            end

            bus.out_valid <= s1_valid;
            // Idle slots leave result and flags holding the last valid value.
            if (s1_valid) begin
                bus.result  <= nxt_result;
                bus.red_and <= &nxt_result[WIDTH-1:0];
                bus.red_or  <= |nxt_result[WIDTH-1:0];
                bus.red_xor <= ^nxt_result[WIDTH-1:0];
                bus.zero    <= (nxt_result == '0);
            end

            if (s1_valid && (s1_op == OP_ACC)) begin
                acc <= acc_next;
            end else if (bus.acc_clr) begin
                acc <= '0;
            end
        end
    end

endmodule

// File: tb/tb_gate_unit_pipe.sv
// tb_gate_unit_pipe
//   Directed bench for gate_unit_pipe at WIDTH=5 with hand-computed
//   expected values for logic ops, ADD/MUL extremes, accumulate with clear,
//   accumulator wrap, idle gaps, mid-stream reset and op_count wrap.
module tb_gate_unit_pipe;

    localparam int WIDTH = 5;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [9:0] m_acc;

    gate_unit_pipe_if #(.WIDTH(WIDTH)) bus ();

    gate_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, then sample 1 ns after the rising edge.
    task automatic step(input logic v, input logic [2:0] o, input logic [4:0] a,
                        input logic [4:0] b, input logic clr);
        bus.in_valid = v;
        bus.op       = o;
        bus.p        = a;
        bus.q        = b;
        bus.acc_clr  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic clr);
        step(1'b0, 3'd0, 5'd0, 5'd0, clr);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        bus.in_valid = 1'b0;
        bus.op       = 3'd0;
        bus.p        = '0;
        bus.q        = '0;
        bus.acc_clr  = 1'b0;
        #12;
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_result",    {22'd0, bus.result},    32'd0);
        check("rst_zero",      {31'd0, bus.zero},      32'd0);
        check("rst_op_count",  {24'd0, bus.op_count},  32'd0);
        rst = 1'b0;

        // Logic ops on p=01010, q=10101.
        step(1'b1, 3'd0, 5'b01010, 5'b10101, 1'b0);
        check("and_latency_not_yet", {31'd0, bus.out_valid}, 32'd0);
        idle(1'b0);
        check("and_valid",  {31'd0, bus.out_valid}, 32'd1);
        check("and_result", {22'd0, bus.result},    32'd0);
        check("and_zero",   {31'd0, bus.zero},      32'd1);
        step(1'b1, 3'd1, 5'b01010, 5'b10101, 1'b0);
        idle(1'b0);
        check("or_result",  {22'd0, bus.result},    32'd31);
        check("or_red_and", {31'd0, bus.red_and},   32'd1);
        check("or_red_xor", {31'd0, bus.red_xor},   32'd1);
        check("or_zero",    {31'd0, bus.zero},      32'd0);
        step(1'b1, 3'd2, 5'b01010, 5'b10101, 1'b0);
        idle(1'b0);
        check("xor_result", {22'd0, bus.result},    32'd31);
        step(1'b1, 3'd3, 5'b01010, 5'b10101, 1'b0);
        idle(1'b0);
        check("nand_result", {22'd0, bus.result},   32'd31);
        step(1'b1, 3'd4, 5'b01010, 5'b10101, 1'b0);
        idle(1'b0);
        check("nor_result", {22'd0, bus.result},    32'd0);
        check("nor_zero",   {31'd0, bus.zero},      32'd1);

        // ADD then MUL back to back at the operand maximum.
        step(1'b1, 3'd5, 5'd31, 5'd31, 1'b0);
        step(1'b1, 3'd6, 5'd31, 5'd31, 1'b0);
        check("add_valid",   {31'd0, bus.out_valid}, 32'd1);
        check("add_result",  {22'd0, bus.result},    32'd62);
        check("add_red_xor", {31'd0, bus.red_xor},   32'd0);
        idle(1'b0);
        check("mul_valid",   {31'd0, bus.out_valid}, 32'd1);
        check("mul_result",  {22'd0, bus.result},    32'd961);
        check("mul_zero",    {31'd0, bus.zero},      32'd0);
        check("mul_red_xor", {31'd0, bus.red_xor},   32'd1);
        check("mul_red_and", {31'd0, bus.red_and},   32'd0);
        idle(1'b0);
        check("idle_valid",  {31'd0, bus.out_valid}, 32'd0);
        check("idle_hold",   {22'd0, bus.result},    32'd961);

        // Consecutive accumulates.
        step(1'b1, 3'd7, 5'd3, 5'd4, 1'b0);
        step(1'b1, 3'd7, 5'd2, 5'd5, 1'b0);
        check("acc1", {22'd0, bus.result}, 32'd12);
        step(1'b1, 3'd7, 5'd31, 5'd31, 1'b0);
        check("acc2", {22'd0, bus.result}, 32'd22);
        idle(1'b0);
        check("acc3", {22'd0, bus.result}, 32'd983);

        // Clear landing in the same cycle as an ACC in stage 2.
        step(1'b1, 3'd7, 5'd1, 5'd1, 1'b0);
        idle(1'b1);
        check("acc_clr_coincident", {22'd0, bus.result}, 32'd1);

        // Lone clear, then a fresh ACC.
        idle(1'b1);
        check("lone_clr_valid", {31'd0, bus.out_valid}, 32'd0);
        check("lone_clr_hold",  {22'd0, bus.result},    32'd1);
        step(1'b1, 3'd7, 5'd2, 5'd2, 1'b0);
        idle(1'b0);
        check("acc_after_clr", {22'd0, bus.result}, 32'd4);

        // Accumulator wrap: seed acc = 63 via clear+ACC(7,9), then add 961 twice.
        step(1'b1, 3'd7, 5'd7, 5'd9, 1'b0);
        step(1'b1, 3'd7, 5'd31, 5'd31, 1'b1);
        m_acc = 10'd63;
        check("acc_seed", {22'd0, bus.result}, {22'd0, m_acc});
        step(1'b0, 3'd0, 5'd31, 5'd31, 1'b0);
        m_acc = m_acc + 10'd961;
        check("acc_wrap1",      {22'd0, bus.result}, {22'd0, m_acc});
        check("acc_wrap1_zero", {31'd0, bus.zero},   32'd1);
        step(1'b1, 3'd7, 5'd31, 5'd31, 1'b0);
        idle(1'b0);
        m_acc = m_acc + 10'd961;
        check("acc_wrap2", {22'd0, bus.result}, {22'd0, m_acc});

        // valid, idle, valid pattern.
        step(1'b1, 3'd2, 5'h0F, 5'h03, 1'b0);
        idle(1'b0);
        check("gap_a_valid",  {31'd0, bus.out_valid}, 32'd1);
        check("gap_a_result", {22'd0, bus.result},    32'd12);
        step(1'b1, 3'd1, 5'h10, 5'h01, 1'b0);
        check("gap_idle_valid", {31'd0, bus.out_valid}, 32'd0);
        check("gap_idle_hold",  {22'd0, bus.result},    32'd12);
        idle(1'b0);
        check("gap_b_valid",  {31'd0, bus.out_valid}, 32'd1);
        check("gap_b_result", {22'd0, bus.result},    32'd17);
        check("op_count_17",  {24'd0, bus.op_count},  32'd17);

        // Reset asserted between edges with two ops in flight.
        step(1'b1, 3'd0, 5'd3, 5'd3, 1'b0);
        bus.in_valid = 1'b1;
        bus.op       = 3'd1;
        bus.p        = 5'd4;
        bus.q        = 5'd4;
        #2 rst = 1'b1;
        #1;
        check("midrst_valid",    {31'd0, bus.out_valid}, 32'd0);
        check("midrst_result",   {22'd0, bus.result},    32'd0);
        check("midrst_op_count", {24'd0, bus.op_count},  32'd0);
        check("midrst_zero",     {31'd0, bus.zero},      32'd0);
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        idle(1'b0);
        check("post_rst_valid1", {31'd0, bus.out_valid}, 32'd0);
        idle(1'b0);
        check("post_rst_valid2", {31'd0, bus.out_valid}, 32'd0);
        step(1'b1, 3'd7, 5'd2, 5'd3, 1'b0);
        check("post_rst_latency", {31'd0, bus.out_valid}, 32'd0);
        idle(1'b0);
        check("post_rst_acc",      {22'd0, bus.result},   32'd6);
        check("post_rst_op_count", {24'd0, bus.op_count}, 32'd1);

        // op_count wrap from a clean reset.
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        check("wrap_start", {24'd0, bus.op_count}, 32'd0);
        for (int i = 0; i < 255; i++) begin
            step(1'b1, 3'd0, 5'd1, 5'd1, 1'b0);
        end
        check("op_count_255", {24'd0, bus.op_count}, 32'd255);
        step(1'b1, 3'd0, 5'd1, 5'd1, 1'b0);
        check("op_count_wrap", {24'd0, bus.op_count}, 32'd0);
        idle(1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
